fp_wb_queue: RTL

Write-back queue for the pipelined FPU's two-write-port floating-point register file. Collects results from up to two producers per cycle (FPU result path and FP load path), buffers them in program order, and drains up to two per cycle onto the register file's x/y write ports. Older entries always go to port x and younger entries to port y, so the register file's y-over-x priority preserves program order on same-register collisions. Also exports a pending-write mask used by the decode-stage interlock.

---
 rtl/fp_wb_queue_if.sv | 34 +++
 rtl/fp_wb_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/fp_wb_queue_if.sv
// Producer-side and register-file-side signals of the FP write-back queue.
// The queue itself takes the slave modport; producers and the register file use master.
interface fp_wb_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in0_valid;
    logic [4:0]    in0_rn;
    logic [31:0]   in0_d;
    logic          in1_valid;
    logic [4:0]    in1_rn;
    logic [31:0]   in1_d;
    logic          in_ready;
    logic          wb_hold;
    logic          wex;
    logic [4:0]    wnx;
    logic [31:0]   dx;
    logic          wey;
    logic [4:0]    wny;
    logic [31:0]   dy;
    logic [31:0]   busy_mask;
    logic [CW-1:0] count;

    modport slave (
        input  in0_valid, in0_rn, in0_d, in1_valid, in1_rn, in1_d, wb_hold,
        output in_ready, wex, wnx, dx, wey, wny, dy, busy_mask, count
    );

    modport master (
        output in0_valid, in0_rn, in0_d, in1_valid, in1_rn, in1_d, wb_hold,
        input  in_ready, wex, wnx, dx, wey, wny, dy, busy_mask, count
    );
endinterface

// File: rtl/fp_wb_queue.sv
// Two-in/two-out program-order write-back queue for the FP register file.
// The oldest entry always leaves on port x, so y-over-x priority in the register file keeps order.
module fp_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          clrn,
    fp_wb_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    rnMem [DEPTH];
    logic [31:0]   dMem  [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          inReady;
    logic [1:0]    enqN;
    logic [1:0]    deqN;
    logic [AW-1:0] headNext;
    logic [AW-1:0] tailNext;
    logic [AW-1:0] offset;
    logic [31:0]   busyMask;

    // Acceptance looks only at the registered count; a same-cycle drain does not help.
    assign inReady  = (count_q <= CW'(DEPTH - 2));
    assign headNext = head_q + AW'(1);
    assign tailNext = tail_q + AW'(1);

    always_comb begin
        enqN = 2'd0;
        if (inReady) begin
            enqN = {1'b0, bus.in0_valid} + {1'b0, bus.in1_valid};
        end
    end

    always_comb begin
        deqN = 2'd0;
        if (!bus.wb_hold) begin
            if (count_q >= CW'(2)) begin
                deqN = 2'd2;
            end else if (count_q == CW'(1)) begin
                deqN = 2'd1;
            end
        end
    end

    always_comb begin
        head_d  = head_q + AW'(deqN);
        tail_d  = tail_q + AW'(enqN);
        count_d = count_q + CW'(enqN) - CW'(deqN);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately unreset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (inReady) begin
            if (bus.in0_valid) begin
                rnMem[tail_q] <= bus.in0_rn;
                dMem[tail_q]  <= bus.in0_d;
            end
            if (bus.in1_valid) begin
                rnMem[bus.in0_valid ? tailNext : tail_q] <= bus.in1_rn;
                dMem[bus.in0_valid ? tailNext : tail_q]  <= bus.in1_d;
            end
        end
    end

    always_comb begin
        bus.wex = 1'b0;
        bus.wnx = 5'd0;
        bus.dx  = 32'd0;
        bus.wey = 1'b0;
        bus.wny = 5'd0;
        bus.dy  = 32'd0;
        if (deqN != 2'd0) begin
            bus.wex = 1'b1;
            bus.wnx = rnMem[head_q];
            bus.dx  = dMem[head_q];
        end
        if (deqN == 2'd2) begin
            bus.wey = 1'b1;
            bus.wny = rnMem[headNext];
            bus.dy  = dMem[headNext];
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        busyMask = 32'd0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - head_q;
            if ({1'b0, offset} < count_q) begin
                busyMask[rnMem[i]] = 1'b1;
            end
        end
    end

    assign bus.busy_mask = busyMask;
    assign bus.in_ready  = inReady;
    assign bus.count     = count_q;
endmodule
